// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int unsigned QDEPTH        = 2;
   localparam logic [31:0] PC_STEP       = 32'd4;
   localparam logic [31:0] PC_R15_OFFSET = 32'd8;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch queue plus the in-order tag FIFO of issued fetch
// addresses; each response pops one tag, which becomes the pushed entry's pc.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [31:0]  push_instr_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic         tag_push_i,
   input  logic [31:0]  tag_pc_i,
   input  logic         tag_pop_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t entries_q [QDEPTH];
   logic [31:0]  tags_q    [QDEPTH];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         tag_rd_q, tag_rd_d;
   logic         tag_wr_q, tag_wr_d;

   // Pointer and occupancy next-state; with two entries a pointer step is a toggle.
   // Tag pointers ignore flush: discarded responses still retire their tags.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      tag_rd_d = tag_rd_q;
      tag_wr_d = tag_wr_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = ~wr_ptr_q;
         if (pop_i)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
      if (tag_push_i) tag_wr_d = ~tag_wr_q;
      if (tag_pop_i)  tag_rd_d = ~tag_rd_q;
   end

   // Storage and pointer registers; reset clears the entries so outputs read zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         entries_q <= '{default: '0};
         tags_q    <= '{default: '0};
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         tag_rd_q  <= '0;
         tag_wr_q  <= '0;
      end else begin
         if (push_i && !flush_i) begin
            entries_q[wr_ptr_q] <= '{instr: push_instr_i, pc: tags_q[tag_rd_q]};
         end
         if (tag_push_i) begin
            tags_q[tag_wr_q] <= tag_pc_i;
         end
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         tag_rd_q <= tag_rd_d;
         tag_wr_q <= tag_wr_d;
      end
   end

   assign head_o  = entries_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// requests to instruction memory and presents buffered words to decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus8,
   input  logic        instr_ready,
   input  logic        PCSrc,
   input  logic [31:0] branch_target
);

   fetch_state_t state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [1:0]   outstanding_q, outstanding_d;
   logic [1:0]   drop_q, drop_d;
   logic [1:0]   count;
   fetch_entry_t head;
   logic         pop, issue, redirect, push, has_credit;

   assign pop      = instr_valid & instr_ready;
   assign redirect = pop & PCSrc;
   assign issue    = imem_req & imem_gnt;
   assign push     = imem_rvalid & (state_q == RUN) & ~redirect;

   // credits = 2 - count - outstanding + pop, tested as a compare so it cannot underflow.
   assign has_credit = ({1'b0, count} + {1'b0, outstanding_q}) < (3'd2 + {2'b00, pop});

   assign imem_req    = (state_q == RUN) & has_credit & ~redirect;
   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (count != 2'd0) & (state_q == RUN);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign pc_plus8    = head.pc + PC_R15_OFFSET;

   assign outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, imem_rvalid};

   // FSM, fetch PC and drop-counter next-state.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            if (redirect) begin
               fetch_pc_d = branch_target & ~32'h0000_0003;
               drop_d     = outstanding_d;
               state_d    = (outstanding_d != 2'd0) ? DRAIN : RUN;
            end
         end
         DRAIN: begin
            if (imem_rvalid) begin
               drop_d = drop_q - 2'd1;
               if (drop_q == 2'd1) state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_queue u_queue (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_instr_i (imem_rdata),
      .pop_i        (pop),
      .flush_i      (redirect),
      .tag_push_i   (issue),
      .tag_pc_i     (fetch_pc_q),
      .tag_pop_i    (imem_rvalid),
      .head_o       (head),
      .count_o      (count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory model feeds the DUT and a
// scoreboard queue of expected instruction addresses is checked on each consume.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_ready, PCSrc;
   logic [31:0] branch_target;

   logic        req0, valid0, req1, valid1;
   logic [31:0] addr0, instr0, pc0, pc8_0, addr1, instr1, pc1, pc8_1;

   logic        sel;
   logic        cur_req, cur_valid;
   logic [31:0] cur_addr, cur_instr, cur_pc, cur_pc8;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] exp_q[$];
   int unsigned lat, cyc, pops;
   int          checks = 0;
   int          errors = 0;

   initial forever #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset),
      .imem_req(req0), .imem_addr(addr0), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(valid0), .instr(instr0), .instr_pc(pc0), .pc_plus8(pc8_0),
      .instr_ready(instr_ready), .PCSrc(PCSrc), .branch_target(branch_target)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req(req1), .imem_addr(addr1), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(valid1), .instr(instr1), .instr_pc(pc1), .pc_plus8(pc8_1),
      .instr_ready(instr_ready), .PCSrc(PCSrc), .branch_target(branch_target)
   );

   assign cur_req   = sel ? req1   : req0;
   assign cur_addr  = sel ? addr1  : addr0;
   assign cur_valid = sel ? valid1 : valid0;
   assign cur_instr = sel ? instr1 : instr0;
   assign cur_pc    = sel ? pc1    : pc0;
   assign cur_pc8   = sel ? pc8_1  : pc8_0;

   function automatic logic [31:0] code(input logic [31:0] a);
      return (a ^ 32'hE3A0_5A00) + 32'h0000_0011;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock: monitor and memory sampling before the edge, memory response after it.
   task automatic step();
      logic [31:0] e;
      pend_t       p;
      #2;
      if (cur_valid && instr_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_instr", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("instr_pc", cur_pc, e);
            check_eq("instr", cur_instr, code(e));
            check_eq("pc_plus8", cur_pc8, e + 32'd8);
         end
      end
      if (!reset) begin
         pend_q.delete();
      end else if (cur_req && imem_gnt) begin
         p.addr = cur_addr;
         p.due  = cyc + lat;
         pend_q.push_back(p);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         p = pend_q.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = code(p.addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input logic s, input int unsigned l);
      reset = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0; imem_gnt = 1'b1;
      sel = s; lat = l;
      exp_q.delete();
      step();
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req"},   {31'b0, cur_req},   32'd0);
      check_eq({tag, "_addr"},  cur_addr,           sel ? 32'hFFFF_FFF8 : 32'h0);
      check_eq({tag, "_valid"}, {31'b0, cur_valid}, 32'd0);
      check_eq({tag, "_instr"}, cur_instr,          32'd0);
      check_eq({tag, "_pc"},    cur_pc,             32'd0);
      check_eq({tag, "_pc8"},   cur_pc8,            32'd8);
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned n = 0;
      instr_ready = 1'b1;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check_eq("drain_done", 32'(exp_q.size()), 32'd0);
      instr_ready = 1'b0;
   endtask

   task automatic wait_head(input logic [31:0] pc, input int unsigned budget);
      int unsigned n = 0;
      while (!(cur_valid && cur_pc == pc) && n < budget) begin
         step();
         n++;
      end
      check_eq("reach_head_valid", {31'b0, cur_valid}, 32'd1);
      check_eq("reach_head_pc", cur_pc, pc);
   endtask

   initial begin
      int unsigned p0;
      int unsigned n;
      reset = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0; branch_target = '0;
      imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      sel = 1'b0; lat = 1; cyc = 0; pops = 0;
      @(negedge clk);

      // Reset state, start-up latency, throughput, then a consumer stall.
      do_reset(1'b0, 1);
      check_reset_outputs("rst");
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
      reset = 1'b1; instr_ready = 1'b1;
      step();
      check_eq("e0_req", {31'b0, cur_req}, 32'd1);
      check_eq("e0_addr", cur_addr, 32'h0);
      check_eq("e0_valid", {31'b0, cur_valid}, 32'd0);
      step();
      check_eq("e1_addr", cur_addr, 32'h4);
      check_eq("e1_valid", {31'b0, cur_valid}, 32'd0);
      step();
      check_eq("e2_addr", cur_addr, 32'h8);
      check_eq("e2_valid", {31'b0, cur_valid}, 32'd1);
      check_eq("e2_pc", cur_pc, 32'h0);
      check_eq("e2_pc8", cur_pc8, 32'h8);
      p0 = pops;
      repeat (4) step();
      check_eq("throughput", pops - p0, 32'd4);
      instr_ready = 1'b0;
      repeat (6) step();
      check_eq("stall_req", {31'b0, cur_req}, 32'd0);
      check_eq("stall_valid", {31'b0, cur_valid}, 32'd1);
      for (int i = 4; i < 12; i++) exp_q.push_back(32'(4 * i));
      drain(40);

      // Grant withheld while requesting 0x10.
      do_reset(1'b0, 1);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      reset = 1'b1; instr_ready = 1'b1;
      n = 0;
      while (!(cur_req && cur_addr == 32'h10) && n < 20) begin
         step();
         n++;
      end
      check_eq("gnt_reach_addr", cur_addr, 32'h10);
      imem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("gnt_hold_req", {31'b0, cur_req}, 32'd1);
         check_eq("gnt_hold_addr", cur_addr, 32'h10);
      end
      imem_gnt = 1'b1;
      step();
      check_eq("gnt_advance", cur_addr, 32'h14);
      drain(40);

      // Redirect with nothing left to drop: three cycles to the new instruction.
      do_reset(1'b0, 1);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
      reset = 1'b1; instr_ready = 1'b1;
      wait_head(32'h8, 20);
      PCSrc = 1'b1; branch_target = 32'h0000_0102;
      step();
      PCSrc = 1'b0; branch_target = '0;
      check_eq("rd0_req", {31'b0, cur_req}, 32'd1);
      check_eq("rd0_addr", cur_addr, 32'h100);
      check_eq("rd0_valid_c1", {31'b0, cur_valid}, 32'd0);
      step();
      check_eq("rd0_valid_c2", {31'b0, cur_valid}, 32'd0);
      step();
      check_eq("rd0_valid_c3", {31'b0, cur_valid}, 32'd1);
      check_eq("rd0_pc", cur_pc, 32'h100);
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      drain(20);

      // Redirect with a response in flight: it is dropped in DRAIN.
      do_reset(1'b0, 3);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h100); exp_q.push_back(32'h104);
      reset = 1'b1; instr_ready = 1'b1;
      wait_head(32'h4, 30);
      PCSrc = 1'b1; branch_target = 32'h0000_0102;
      step();
      PCSrc = 1'b0; branch_target = '0;
      check_eq("drain_req_c1", {31'b0, cur_req}, 32'd0);
      check_eq("drain_valid_c1", {31'b0, cur_valid}, 32'd0);
      step();
      check_eq("drain_req_c2", {31'b0, cur_req}, 32'd0);
      check_eq("drain_valid_c2", {31'b0, cur_valid}, 32'd0);
      step();
      check_eq("drain_exit_req", {31'b0, cur_req}, 32'd1);
      check_eq("drain_exit_addr", cur_addr, 32'h100);
      drain(30);

      // Reset mid-operation with one queued instruction and one in flight.
      do_reset(1'b0, 2);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      reset = 1'b1; instr_ready = 1'b1;
      wait_head(32'h4, 20);
      instr_ready = 1'b0;
      reset = 1'b0;
      step();
      check_reset_outputs("midrst");
      exp_q.delete();
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      reset = 1'b1;
      step();
      check_eq("midrst_restart_req", {31'b0, cur_req}, 32'd1);
      check_eq("midrst_restart_addr", cur_addr, 32'h0);
      drain(20);

      // Fetch address wraps through 2^32.
      do_reset(1'b1, 1);
      check_reset_outputs("wrap_rst");
      exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      reset = 1'b1; instr_ready = 1'b1;
      step();
      check_eq("wrap_addr0", cur_addr, 32'hFFFF_FFF8);
      step();
      check_eq("wrap_addr1", cur_addr, 32'hFFFF_FFFC);
      step();
      check_eq("wrap_addr2", cur_addr, 32'h0);
      check_eq("wrap_pc", cur_pc, 32'hFFFF_FFF8);
      check_eq("wrap_pc8", cur_pc8, 32'h0);
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
